// File: rtl/spi_rx_sync.sv
// SPI slave receiver: synchronises raw SPI pins into clk, shifts frames in on
// sclk fall, shifts readback out on sclk rise, and latches complete frames.
module spi_rx_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk,
  input  logic             cs,
  input  logic             mosi,
  output logic             miso,
  output logic [WIDTH-1:0] reg_out,
  output logic             reg_valid,
  output logic             frame_err
);

  localparam logic [1:0] WAIT_IDLE = 2'd0;
  localparam logic [1:0] IDLE      = 2'd1;
  localparam logic [1:0] SHIFT     = 2'd2;

  localparam logic [7:0] CNT_MAX  = 8'd255;
  localparam logic [7:0] CNT_FULL = 8'(WIDTH);

  logic [2:0] raw_in;
  logic [2:0] sync_out;

  assign raw_in = {mosi, cs, sclk};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain_reg;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          chain_reg <= '0;
        end else begin
          chain_reg <= {chain_reg[SYNC_STAGES-2:0], raw_in[gi]};
        end
      end
      assign sync_out[gi] = chain_reg[SYNC_STAGES-1];
    end
  endgenerate

  logic sclk_sync, cs_sync, mosi_sync;
  assign sclk_sync = sync_out[0];
  assign cs_sync   = sync_out[1];
  assign mosi_sync = sync_out[2];

  logic sclk_prev_reg, cs_prev_reg;
  logic sclk_fall_reg, sclk_rise_reg, cs_fall_reg, cs_rise_reg;

  // Edge pulses are registered so sclk and cs events reach the FSM in the same
  // cycle they were seen together, keeping cs-rise priority well defined.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_prev_reg <= 1'b0;
      cs_prev_reg   <= 1'b0;
      sclk_fall_reg <= 1'b0;
      sclk_rise_reg <= 1'b0;
      cs_fall_reg   <= 1'b0;
      cs_rise_reg   <= 1'b0;
    end else begin
      sclk_prev_reg <= sclk_sync;
      cs_prev_reg   <= cs_sync;
      sclk_fall_reg <= sclk_prev_reg & ~sclk_sync;
      sclk_rise_reg <= ~sclk_prev_reg & sclk_sync;
      cs_fall_reg   <= cs_prev_reg & ~cs_sync;
      cs_rise_reg   <= ~cs_prev_reg & cs_sync;
    end
  end

  logic [1:0]       state_reg;
  logic [7:0]       bit_cnt_reg;
  logic [WIDTH-1:0] rx_reg;
  logic [WIDTH-1:0] tx_reg;
  logic [WIDTH-1:0] reg_out_reg;
  logic             reg_valid_reg;
  logic             frame_err_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= WAIT_IDLE;
      bit_cnt_reg   <= '0;
      rx_reg        <= '0;
      tx_reg        <= '0;
      reg_out_reg   <= '0;
      reg_valid_reg <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      reg_valid_reg <= 1'b0;
      frame_err_reg <= 1'b0;
      case (state_reg)
        WAIT_IDLE: begin
          // A reset mid-frame must not resume that frame; wait for cs to deassert.
          if (cs_sync) state_reg <= IDLE;
        end
        IDLE: begin
          if (cs_fall_reg) begin
            bit_cnt_reg <= '0;
            tx_reg      <= reg_out_reg;
            state_reg   <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_rise_reg) begin
            state_reg <= IDLE;
            if (bit_cnt_reg == CNT_FULL) begin
              reg_out_reg   <= rx_reg;
              reg_valid_reg <= 1'b1;
            end else if (bit_cnt_reg != 8'd0) begin
              frame_err_reg <= 1'b1;
            end
          end else if (sclk_fall_reg) begin
            rx_reg <= {rx_reg[WIDTH-2:0], mosi_sync};
            if (bit_cnt_reg != CNT_MAX) bit_cnt_reg <= bit_cnt_reg + 8'd1;
          end else if (sclk_rise_reg && bit_cnt_reg != 8'd0) begin
            tx_reg <= {tx_reg[WIDTH-2:0], 1'b0};
          end
        end
        default: state_reg <= WAIT_IDLE;
      endcase
    end
  end

  assign miso      = (state_reg == SHIFT) ? tx_reg[WIDTH-1] : 1'b0;
  assign reg_out   = reg_out_reg;
  assign reg_valid = reg_valid_reg;
  assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_spi_rx_sync.sv
// Directed bench for spi_rx_sync: a table of SPI frames with expected latch,
// pulse and readback behaviour, plus hand sequences for latency and reset.
module tb_spi_rx_sync;

  logic       clk;
  logic       rst_n;
  logic       sclk;
  logic       cs;
  logic       mosi;
  logic       miso;
  logic [7:0] reg_out;
  logic       reg_valid;
  logic       frame_err;

  spi_rx_sync #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (sclk),
    .cs        (cs),
    .mosi      (mosi),
    .miso      (miso),
    .reg_out   (reg_out),
    .reg_valid (reg_valid),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int valid_total = 0;
  int err_total   = 0;
  int both_total  = 0;

  always @(negedge clk) begin
    if (reg_valid) valid_total++;
    if (frame_err) err_total++;
    if (reg_valid && frame_err) both_total++;
  end

  typedef struct {
    logic [15:0] data;
    int          nbits;
    logic        merge;
    logic [7:0]  exp_reg;
    int          exp_valid;
    int          exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Host in CPOL=0 / CPHA=1 style: raise sclk and present data, lower sclk after
  // 4 clk; miso is checked just before each fall against the readback model.
  task automatic send_bits(input logic [15:0] data, input int nbits, input logic [7:0] prev,
                           input logic merge, input string tag);
    logic [15:0] shifted;
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b1;
      mosi = data[nbits-1-i];
      wait_cycles(4);
      shifted = {8'h00, prev} << i;
      check($sformatf("%s miso bit%0d", tag, i), {31'd0, miso}, {31'd0, shifted[7]});
      sclk = 1'b0;
      if (merge && i == nbits - 1) cs = 1'b1;
      wait_cycles(4);
    end
  endtask

  task automatic run_frame(input vec_t v, input logic [7:0] prev, input string tag);
    int v0, e0;
    v0 = valid_total;
    e0 = err_total;
    cs = 1'b0;
    wait_cycles(4);
    send_bits(v.data, v.nbits, prev, v.merge, tag);
    if (!v.merge) cs = 1'b1;
    wait_cycles(8);
    check($sformatf("%s valid_pulses", tag), valid_total - v0, v.exp_valid);
    check($sformatf("%s err_pulses", tag), err_total - e0, v.exp_err);
    check($sformatf("%s reg_out", tag), {24'd0, reg_out}, {24'd0, v.exp_reg});
    check($sformatf("%s miso_idle", tag), {31'd0, miso}, 32'd0);
  endtask

  initial begin
    logic [7:0] prev_reg;
    int v0, e0;
    vec_t fr;

    vecs[0] = '{data: 16'h00A5, nbits: 8, merge: 1'b0, exp_reg: 8'hA5, exp_valid: 1, exp_err: 0};
    vecs[1] = '{data: 16'h003C, nbits: 8, merge: 1'b0, exp_reg: 8'h3C, exp_valid: 1, exp_err: 0};
    vecs[2] = '{data: 16'h0055, nbits: 7, merge: 1'b0, exp_reg: 8'h3C, exp_valid: 0, exp_err: 1};
    vecs[3] = '{data: 16'h01FF, nbits: 9, merge: 1'b0, exp_reg: 8'h3C, exp_valid: 0, exp_err: 1};
    vecs[4] = '{data: 16'h0000, nbits: 0, merge: 1'b0, exp_reg: 8'h3C, exp_valid: 0, exp_err: 0};
    vecs[5] = '{data: 16'h00C3, nbits: 8, merge: 1'b0, exp_reg: 8'hC3, exp_valid: 1, exp_err: 0};
    vecs[6] = '{data: 16'h0081, nbits: 8, merge: 1'b1, exp_reg: 8'hC3, exp_valid: 0, exp_err: 1};
    vecs[7] = '{data: 16'h0000, nbits: 8, merge: 1'b0, exp_reg: 8'h00, exp_valid: 1, exp_err: 0};

    rst_n = 1'b0;
    sclk  = 1'b0;
    cs    = 1'b1;
    mosi  = 1'b0;
    wait_cycles(4);
    check("reset reg_out", {24'd0, reg_out}, 32'd0);
    check("reset reg_valid", {31'd0, reg_valid}, 32'd0);
    check("reset frame_err", {31'd0, frame_err}, 32'd0);
    check("reset miso", {31'd0, miso}, 32'd0);
    rst_n = 1'b1;
    wait_cycles(8);

    prev_reg = 8'h00;
    for (int k = 0; k < 8; k++) begin
      run_frame(vecs[k], prev_reg, $sformatf("vec%0d", k));
      $display("vec%0d: %0d bits data 0x%0h -> reg_out 0x%0h", k, vecs[k].nbits, vecs[k].data, reg_out);
      prev_reg = vecs[k].exp_reg;
    end

    // reg_valid must appear exactly in the cycle after the third edge following cs rise.
    cs = 1'b0;
    wait_cycles(4);
    send_bits(16'h005A, 8, prev_reg, 1'b0, "lat");
    cs = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("lat E%0d reg_valid", k), {31'd0, reg_valid}, (k == 3) ? 32'd1 : 32'd0);
    end
    check("lat reg_out", {24'd0, reg_out}, 32'h5A);
    $display("latency frame: reg_out 0x%0h", reg_out);
    prev_reg = 8'h5A;
    wait_cycles(4);

    // Reset mid-frame with cs held low: the remaining bits must be ignored.
    v0 = valid_total;
    e0 = err_total;
    cs = 1'b0;
    wait_cycles(4);
    send_bits(16'h000F, 4, prev_reg, 1'b0, "rst_pre");
    rst_n = 1'b0;
    wait_cycles(2);
    rst_n = 1'b1;
    check("rst_mid reg_out", {24'd0, reg_out}, 32'd0);
    send_bits(16'h000F, 4, 8'h00, 1'b0, "rst_post");
    cs = 1'b1;
    wait_cycles(8);
    check("rst_mid valid_pulses", valid_total - v0, 32'd0);
    check("rst_mid err_pulses", err_total - e0, 32'd0);
    check("rst_mid reg_out_after", {24'd0, reg_out}, 32'd0);
    $display("reset mid-frame: reg_out 0x%0h", reg_out);

    fr = '{data: 16'h0001, nbits: 8, merge: 1'b0, exp_reg: 8'h01, exp_valid: 1, exp_err: 0};
    run_frame(fr, 8'h00, "post_rst");
    $display("post-reset frame: reg_out 0x%0h", reg_out);

    check("never both pulses", both_total, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
